// File: rtl/mul_div_unit_pkg.sv
// Shared RV32M definitions: funct3 encodings, FSM state encoding and
// per-op operand signedness helpers.
package riscv_m_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the mul/div engine.
interface mul_div_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;

  modport master (output start, flush, op, A, B, input busy, done, Result);
  modport slave  (input start, flush, op, A, B, output busy, done, Result);
endinterface

// File: rtl/mul_div_unit_md_sign_fix.sv
// Conditional two's-complement negation; used both to take operand
// magnitudes on entry and to restore result signs on exit.
module md_sign_fix #(parameter int W = 32) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? -val : val;
endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: XLEN-step shift-add multiply and
// restoring divide over magnitudes, with a fast path for the divide corner cases.
module mul_div_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst,
  mul_div_unit_if.slave   bus
);

  localparam int CW = $clog2(XLEN);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   result_q;

  // entry: magnitudes and fast-path detection on the raw request
  logic            neg_a, neg_b, accept, div_zero, div_ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  assign neg_a    = a_signed(bus.op) & bus.A[XLEN-1];
  assign neg_b    = b_signed(bus.op) & bus.B[XLEN-1];
  assign accept   = (state == S_IDLE) && bus.start && !bus.flush;
  assign div_zero = (bus.B == '0);
  assign div_ovf  = ((bus.op == MD_DIV) || (bus.op == MD_REM)) &&
                    (bus.A == {1'b1, {(XLEN-1){1'b0}}}) && (bus.B == '1);
  assign fast     = bus.op[2] && (div_zero || div_ovf);
  // op[1] separates REM/REMU from DIV/DIVU
  assign fast_res = div_zero ? (bus.op[1] ? bus.A : '1)
                             : (bus.op[1] ? '0 : bus.A);

  md_sign_fix #(.W(XLEN)) u_mag_a (.val(bus.A), .neg(neg_a), .res(mag_a));
  md_sign_fix #(.W(XLEN)) u_mag_b (.val(bus.B), .neg(neg_b), .res(mag_b));

  // one iteration: acc holds {partial, multiplier} or {remainder, quotient}
  logic [XLEN-1:0]   hi, lo, ddiff;
  logic [XLEN:0]     msum, dsh;
  logic              dge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt;

  assign hi      = acc[2*XLEN-1:XLEN];
  assign lo      = acc[XLEN-1:0];
  assign msum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {msum, lo[XLEN-1:1]};
  assign dsh     = {hi, lo[XLEN-1]};
  assign dge     = (dsh >= {1'b0, opnd});
  assign ddiff   = dsh[XLEN-1:0] - opnd;
  assign div_nxt = {dge ? ddiff : dsh[XLEN-1:0], lo[XLEN-2:0], dge};
  assign acc_nxt = op_q[2] ? div_nxt : mul_nxt;

  // exit: sign restoration on the final iteration's value
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, calc_res;

  md_sign_fix #(.W(2*XLEN)) u_fix_p (.val(acc_nxt), .neg(neg_q), .res(prod_s));
  md_sign_fix #(.W(XLEN))   u_fix_q (.val(acc_nxt[XLEN-1:0]), .neg(neg_q), .res(quo_s));
  md_sign_fix #(.W(XLEN))   u_fix_r (.val(acc_nxt[2*XLEN-1:XLEN]), .neg(neg_r), .res(rem_s));

  always_comb begin
    calc_res = prod_s[2*XLEN-1:XLEN];
    if (op_q[2])                 calc_res = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'b00) calc_res = prod_s[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q  <= bus.op;
          cnt   <= '0;
          neg_q <= neg_a ^ neg_b;
          neg_r <= neg_a;
          acc   <= {{XLEN{1'b0}}, bus.op[2] ? mag_a : mag_b};
          opnd  <= bus.op[2] ? mag_b : mag_a;
          if (fast) begin
            result_q <= fast_res;
            state    <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            result_q <= calc_res;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == S_CALC);
  assign bus.done   = (state == S_DONE);
  assign bus.Result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized checks of mul_div_unit against a plain-arithmetic
// 64-bit reference model.
module tb_mul_div_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_unit_if #(.XLEN(XLEN)) bus();
  mul_div_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp;
    int lat, dcyc, bad;
    exp = ref_md(op, a, b);
    lat = is_fast(op, a, b) ? 1 : XLEN + 1;
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.op = 3'($urandom);
    dcyc = 0; bad = 0;
    for (int c = 1; c <= XLEN + 8; c++) begin
      if (bus.done) begin dcyc = c; break; end
      if (bus.busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, dcyc, lat);
    chk({tag, "_busy_window"}, bad, 0);
    chk({tag, "_result"}, bus.Result, exp);
    chk({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
    chk({tag, "_result_hold"}, bus.Result, exp);
  endtask

  initial begin
    logic [31:0] prev, a, b, exp;
    logic [2:0]  op;
    int nd, dcyc;

    rst = 1'b0; bus.start = 1'b0; bus.flush = 1'b0;
    bus.op = '0; bus.A = '0; bus.B = '0;
    #12;
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_done", {31'b0, bus.done}, 32'd0);
    chk("reset_result", bus.Result, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    chk("mul_7_m3_literal", bus.Result, 32'hFFFF_FFEB);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    chk("mulh_min_literal", bus.Result, 32'h4000_0000);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    chk("mulhu_max_literal", bus.Result, 32'hFFFF_FFFE);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    chk("div_m7_2_literal", bus.Result, 32'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    chk("rem_m7_2_literal", bus.Result, 32'hFFFF_FFFF);
    run_op(3'b101, 32'd100, 32'd7, "divu_100_7");
    chk("divu_100_7_literal", bus.Result, 32'd14);
    run_op(3'b111, 32'd100, 32'd7, "remu_100_7");
    chk("remu_100_7_literal", bus.Result, 32'd2);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf_literal", bus.Result, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    chk("rem_ovf_literal", bus.Result, 32'd0);

    // DIV 5/0 fast path, start held into DONE: REMU 5/0 must wait for IDLE
    bus.start = 1'b1; bus.op = 3'b100; bus.A = 32'd5; bus.B = 32'd0;
    @(negedge clk);
    chk("div_by0_done", {31'b0, bus.done}, 32'd1);
    chk("div_by0_result", bus.Result, 32'hFFFF_FFFF);
    bus.op = 3'b111;
    @(negedge clk);
    chk("start_in_done_ignored", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("remu_by0_done", {31'b0, bus.done}, 32'd1);
    chk("remu_by0_result", bus.Result, 32'd5);
    @(negedge clk);
    chk("remu_by0_pulse", {31'b0, bus.done}, 32'd0);

    // flush mid-CALC, then an immediate new start
    prev = bus.Result;
    bus.start = 1'b1; bus.op = 3'b101; bus.A = 32'd1000; bus.B = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 9; c++) begin
      if (bus.done) nd++;
      @(negedge clk);
    end
    chk("flush_busy_before", {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy_after", {31'b0, bus.busy}, 32'd0);
    chk("flush_no_done", nd + int'(bus.done), 0);
    chk("flush_result_kept", bus.Result, prev);
    run_op(3'b101, 32'd100, 32'd7, "after_flush");

    // flush wins over start in IDLE
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b000; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_prio_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("flush_prio_done", {31'b0, bus.done}, 32'd0);

    // second start while busy is ignored
    a = $urandom; b = $urandom; exp = ref_md(3'b000, a, b);
    bus.start = 1'b1; bus.op = 3'b000; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    dcyc = 0;
    for (int c = 1; c <= XLEN + 8; c++) begin
      if (bus.done) begin dcyc = c; break; end
      bus.start = (c == 5);
      if (c == 5) begin bus.op = 3'b100; bus.A = 32'd1; bus.B = 32'd1; end
      @(negedge clk);
    end
    chk("busy_start_latency", dcyc, XLEN + 1);
    chk("busy_start_result", bus.Result, exp);
    @(negedge clk);

    // async reset mid-CALC
    bus.start = 1'b1; bus.op = 3'b101; bus.A = 32'hFFFF_0000; bus.B = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 19; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_mid_done", {31'b0, bus.done}, 32'd0);
    chk("rst_mid_result", bus.Result, 32'd0);
    @(negedge clk); rst = 1'b1;
    nd = 0;
    for (int c = 0; c < XLEN + 8; c++) begin
      if (bus.done || bus.busy) nd++;
      @(negedge clk);
    end
    chk("rst_mid_no_activity", nd, 0);

    // randomized ops, with zero and -1 divisors mixed in
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
